// File: rtl/regport_arb_pkg.sv
// Shared defaults, types and helpers for the register-file read-port arbiter.
package regport_arb_pkg;

    localparam int unsigned NREQ_DEF   = 4;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 64;

    typedef logic [$clog2(NREQ_DEF)-1:0] req_id_t;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/regport_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regport_arbiter.sv
// Round-robin arbiter for a spare register-file read port with a two-stage response path.
// Optional grant locking is enabled by defining REGPORT_ARB_LOCK_EN.
module regport_arbiter
    import regport_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = NREQ_DEF,
    parameter  int unsigned ADDR_W = ADDR_W_DEF,
    parameter  int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
`ifdef REGPORT_ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    input  logic                   stall,
    output logic [NREQ-1:0]        gnt,
    output logic [ADDR_W-1:0]      rf_raddr,
    input  logic [DATA_W-1:0]      rf_rdata,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_data
);

    logic [IDW-1:0]    ptr;
    logic              s1_v;
    logic [IDW-1:0]    s1_id;

    logic [NREQ-1:0]   pick_req;
    logic [NREQ-1:0]   pick_gnt;
    logic [IDW-1:0]    pick_idx;
    logic              pick_any;

    logic              win;
    logic [IDW-1:0]    win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic              keep_ptr;

`ifdef REGPORT_ARB_LOCK_EN
    logic [IDW-1:0]    last_id;
    logic              lock_v;
    logic              lock_hit;
`endif

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (pick_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        pick_req = (reset_n && !stall) ? req : '0;
        gnt      = pick_gnt;
        win_idx  = pick_idx;
        win      = pick_any;
        keep_ptr = 1'b0;
`ifdef REGPORT_ARB_LOCK_EN
        // A locked owner overrides the rotation without disturbing ptr.
        lock_hit = lock_v && req[last_id] && lock[last_id] && reset_n && !stall;
        if (lock_hit) begin
            gnt          = '0;
            gnt[last_id] = 1'b1;
            win_idx      = last_id;
            win          = 1'b1;
            keep_ptr     = 1'b1;
        end
`endif
        win_addr = req_addr[32'(win_idx)*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr       <= '0;
            rf_raddr  <= '0;
            s1_v      <= 1'b0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
`ifdef REGPORT_ARB_LOCK_EN
            last_id   <= '0;
            lock_v    <= 1'b0;
`endif
        end else begin
            s1_v <= win;
            if (win) begin
                rf_raddr <= win_addr;
                s1_id    <= win_idx;
                if (!keep_ptr)
                    ptr <= IDW'(wrap_inc(32'(win_idx), NREQ));
            end
            rsp_valid <= s1_v;
            if (s1_v) begin
                rsp_data <= rf_rdata;
                rsp_id   <= s1_id;
            end
`ifdef REGPORT_ARB_LOCK_EN
            if (win) begin
                last_id <= win_idx;
                lock_v  <= lock[win_idx];
            end else if (!(req[last_id] && lock[last_id])) begin
                lock_v  <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regport_arbiter.sv
// Randomized self-checking bench for regport_arbiter against a queue-based response model.
module tb_regport_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic                   stall;
    logic [NREQ-1:0]        gnt;
    logic [ADDR_W-1:0]      rf_raddr;
    logic [DATA_W-1:0]      rf_rdata;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [DATA_W-1:0]      rsp_data;

    logic [DATA_W-1:0] mem [32];

    always #5 clk = ~clk;

    assign rf_rdata = mem[rf_raddr];

    regport_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_addr  (req_addr),
        .stall     (stall),
        .gnt       (gnt),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: pending responses with the cycle they become visible.
    typedef struct {
        int          due;
        int          id;
        logic [63:0] data;
    } rsp_t;

    rsp_t        q[$];
    int          cyc;
    int          m_ptr;
    logic [4:0]  m_raddr;
    int          last_id;
    logic [63:0] last_data;

    task automatic model_reset();
        m_ptr     = 0;
        m_raddr   = '0;
        last_id   = 0;
        last_data = '0;
        q.delete();
    endtask

    task automatic step(input logic [3:0] r, input logic [19:0] a, input logic st, input logic rn);
        int          win;
        logic [3:0]  eg;
        logic        ev;
        logic [4:0]  wa;
        @(negedge clk);
        req      = r;
        req_addr = a;
        stall    = st;
        reset_n  = rn;
        #1;
        win = -1;
        if (rn && !st) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (win < 0 && r[c]) win = c;
            end
        end
        eg = (win >= 0) ? 4'(1 << win) : 4'd0;
        ev = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev        = 1'b1;
            last_id   = q[0].id;
            last_data = q[0].data;
            void'(q.pop_front());
        end
        check_val("gnt",       64'(gnt),       64'(eg));
        check_val("rf_raddr",  64'(rf_raddr),  64'(m_raddr));
        check_val("rsp_valid", 64'(rsp_valid), 64'(ev));
        check_val("rsp_id",    64'(rsp_id),    64'(last_id));
        check_val("rsp_data",  rsp_data,       last_data);
        @(posedge clk);
        cyc++;
        if (!rn) begin
            model_reset();
        end else if (win >= 0) begin
            wa      = a[win*ADDR_W +: ADDR_W];
            m_raddr = wa;
            q.push_back('{cyc + 1, win, mem[wa]});
            m_ptr   = (win + 1) % NREQ;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = {$urandom(), $urandom()};
        mem[7]   = 64'hA5;
        reset_n  = 1'b0;
        req      = 4'hF;
        stall    = 1'b0;
        req_addr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        cyc = 0;

        // Reset held with all requests high.
        step(4'hF, 20'h0, 1'b0, 1'b0);
        step(4'hF, 20'h0, 1'b0, 1'b0);

        // Single request to requester 2 at address 7.
        step(4'b0100, 20'(7) << 10, 1'b0, 1'b1);
        repeat (3) step(4'b0000, 20'h0, 1'b0, 1'b1);

        // Fairness from ptr 0, including address 31 pass-through.
        step(4'b0000, 20'h0, 1'b0, 1'b0);
        repeat (8) step(4'hF, {5'd31, 5'd3, 5'd2, 5'd1}, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 20'h0, 1'b0, 1'b1);

        // Wrap and skip: grant 2 leaves ptr at 3.
        step(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 1'b0, 1'b1);
        step(4'b0011, {5'd0, 5'd0, 5'd12, 5'd11}, 1'b0, 1'b1);
        step(4'b0011, {5'd0, 5'd0, 5'd12, 5'd11}, 1'b0, 1'b1);

        // Stall with a read in flight.
        step(4'b1010, {5'd20, 5'd0, 5'd21, 5'd0}, 1'b0, 1'b1);
        repeat (3) step(4'b1010, {5'd20, 5'd0, 5'd21, 5'd0}, 1'b1, 1'b1);
        repeat (2) step(4'b1010, {5'd20, 5'd0, 5'd21, 5'd0}, 1'b0, 1'b1);
        repeat (2) step(4'b0000, 20'h0, 1'b0, 1'b1);

        // Random traffic with occasional stalls and mid-operation resets.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom()), 20'($urandom()),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) != 0));
        end
        repeat (3) step(4'b0000, 20'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
